// File: rtl/ps2_frame_decoder_if.sv
// Key-event bundle from ps2_frame_decoder to the keyboard ring buffer.
// The decoder drives master; the buffer write side consumes slave.
interface ps2_frame_decoder_if;
   logic [7:0] code;
   logic       is_break;
   logic       is_ext;
   logic       code_valid;
   logic       frame_err;
   logic       busy;

   modport master (
      output code, is_break, is_ext,
      output code_valid, frame_err, busy
   );

   modport slave (
      input code, is_break, is_ext,
      input code_valid, frame_err, busy
   );
endinterface

// File: rtl/ps2_frame_decoder.sv
// PS/2 deframer: sync, falling-edge detect, 11-bit frames, E0/F0 folding.
// Define PS2_FILTER_EN to glitch-filter the synchronised PS2_CLK.
module ps2_frame_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 100000,
   parameter int FILTER_LEN  = 8
) (
   input  logic CLK100MHZ,
   input  logic reset,
   input  logic PS2_CLK,
   input  logic PS2_DATA,
   ps2_frame_decoder_if.master ev
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_param
      $error("ps2_frame_decoder: bad SYNC_STAGES/FILTER_LEN");
   end

   typedef enum logic [1:0] {IDLE, SHIFT, CHECK, EMIT} state_t;

   state_t state, state_n;

   logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
   logic            clk_lvl, clk_prev, fall, dat_s;
   logic [3:0]      bitcnt;
   logic [7:0]      sr;
   logic            par, stop_b;
   logic [TW-1:0]   tmo_cnt;
   logic            ext_pend, brk_pend;
   logic [7:0]      code_q;
   logic            brk_q, ext_q, valid_q, err_q;

   logic go_shift, do_shift, do_par, do_stop;
   logic do_err, do_emit, set_ext, set_brk;

   assign dat_s = dat_sync[SYNC_STAGES-1];
   assign fall  = clk_prev & ~clk_lvl;

`ifdef PS2_FILTER_EN
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

   logic [FW-1:0] filt_cnt;
   logic          filt_lvl;

   // Level flips only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         filt_lvl <= 1'b1;
         filt_cnt <= '0;
      end else if (clk_sync[SYNC_STAGES-1] == filt_lvl) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
         filt_lvl <= clk_sync[SYNC_STAGES-1];
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + FW'(1);
      end
   end

   assign clk_lvl = filt_lvl;
`else
   assign clk_lvl = clk_sync[SYNC_STAGES-1];
`endif

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n  = state;
      go_shift = 1'b0;
      do_shift = 1'b0;
      do_par   = 1'b0;
      do_stop  = 1'b0;
      do_err   = 1'b0;
      do_emit  = 1'b0;
      set_ext  = 1'b0;
      set_brk  = 1'b0;
      unique case (state)
         IDLE: begin
            if (fall && !dat_s) begin
               state_n  = SHIFT;
               go_shift = 1'b1;
            end
         end
         SHIFT: begin
            if (fall) begin
               unique case (1'b1)
                  (bitcnt < 4'd8): do_shift = 1'b1;
                  (bitcnt == 4'd8): do_par = 1'b1;
                  default: begin
                     do_stop = 1'b1;
                     state_n = CHECK;
                  end
               endcase
            end else if (tmo_cnt == TMO_LAST) begin
               do_err  = 1'b1;
               state_n = IDLE;
            end
         end
         CHECK: begin
            if (!(^{sr, par}) || !stop_b) begin
               do_err  = 1'b1;
               state_n = IDLE;
            end else begin
               state_n = EMIT;
               unique case (sr)
                  8'hE0:   set_ext = 1'b1;
                  8'hF0:   set_brk = 1'b1;
                  default: do_emit = 1'b1;
               endcase
            end
         end
         EMIT:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Event outputs are registered off CHECK so they land in the EMIT cycle.
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         clk_sync <= '1;
         dat_sync <= '1;
         clk_prev <= 1'b1;
         bitcnt   <= '0;
         sr       <= '0;
         par      <= 1'b0;
         stop_b   <= 1'b0;
         tmo_cnt  <= '0;
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
         code_q   <= '0;
         brk_q    <= 1'b0;
         ext_q    <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DATA};
         clk_prev <= clk_lvl;
         if (go_shift)
            bitcnt <= '0;
         else if (state == SHIFT && fall)
            bitcnt <= bitcnt + 4'd1;
         if (do_shift) sr <= {dat_s, sr[7:1]};
         if (do_par)   par <= dat_s;
         if (do_stop)  stop_b <= dat_s;
         if (state == SHIFT && !fall)
            tmo_cnt <= tmo_cnt + TW'(1);
         else
            tmo_cnt <= '0;
         valid_q <= do_emit;
         err_q   <= do_err;
         if (do_err) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end else if (set_ext) begin
            ext_pend <= 1'b1;
         end else if (set_brk) begin
            brk_pend <= 1'b1;
         end else if (do_emit) begin
            code_q   <= sr;
            ext_q    <= ext_pend;
            brk_q    <= brk_pend;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end
      end
   end

   assign ev.code       = code_q;
   assign ev.is_break   = brk_q;
   assign ev.is_ext     = ext_q;
   assign ev.code_valid = valid_q;
   assign ev.frame_err  = err_q;
   assign ev.busy       = (state != IDLE);

endmodule

// File: tb/tb_ps2_frame_decoder.sv
// Bench for ps2_frame_decoder: directed vector table, corner sequences,
// and random frames against a prefix-folding event model.
`timescale 1ns/1ps
module tb_ps2_frame_decoder;

   localparam int SYNC = 2;
   localparam int TMO  = 600;
   localparam int FLEN = 8;
   localparam int H    = 20;
`ifdef PS2_FILTER_EN
   localparam int LAT = 4 + FLEN;
`else
   localparam int LAT = 4;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;

   always #5 clk = ~clk;

   ps2_frame_decoder_if ev();

   ps2_frame_decoder #(
      .SYNC_STAGES(SYNC),
      .TIMEOUT_CYC(TMO),
      .FILTER_LEN(FLEN)
   ) dut (
      .CLK100MHZ(clk),
      .reset(reset),
      .PS2_CLK(ps2_clk),
      .PS2_DATA(ps2_data),
      .ev(ev)
   );

   typedef struct packed {
      logic [7:0] code;
      logic       brk;
      logic       ext;
   } evt_t;

   typedef struct {
      logic [7:0] b;
      bit         bad;
      int         nv;
      int         ne;
      logic [7:0] code;
      bit         brk;
      bit         ext;
   } vec_t;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int err_cnt = 0;
   int overlap = 0;
   int last_valid_cyc = 0;
   int last_err_cyc = 0;
   int last_fall_cyc = 0;
   int stop_cyc = 0;
   int exp_err = 0;
   bit m_ext = 0;
   bit m_brk = 0;
   evt_t got_q[$];
   evt_t exp_q[$];
   vec_t vt[19];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (ev.code_valid) begin
            got_q.push_back({ev.code, ev.is_break, ev.is_ext});
            last_valid_cyc = cyc;
         end
         if (ev.frame_err) begin
            err_cnt++;
            last_err_cyc = cyc;
         end
         if (ev.code_valid && ev.frame_err) overlap++;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(string name, int act, int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic clk_wait(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(logic [7:0] b, bit bad_par, int nbits);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         clk_wait(H / 2);
         ps2_clk = 1'b0;
         last_fall_cyc = cyc;
         if (i == 10) stop_cyc = cyc;
         clk_wait(H);
         ps2_clk = 1'b1;
         clk_wait(H / 2);
      end
      ps2_data = 1'b1;
   endtask

   // Event model: prefixes accumulate, any error drops them.
   task automatic model(logic [7:0] b, bit bad_par);
      if (bad_par) begin
         m_ext = 0;
         m_brk = 0;
         exp_err++;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         exp_q.push_back({b, m_brk, m_ext});
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   initial begin
      int d;
      logic [7:0] rb;
      bit rbad;

      vt[0]  = '{8'h1C, 0, 1, 0, 8'h1C, 0, 0};
      vt[1]  = '{8'hF0, 0, 0, 0, 8'h1C, 0, 0};
      vt[2]  = '{8'h1C, 0, 1, 0, 8'h1C, 1, 0};
      vt[3]  = '{8'hE0, 0, 0, 0, 8'h1C, 1, 0};
      vt[4]  = '{8'hF0, 0, 0, 0, 8'h1C, 1, 0};
      vt[5]  = '{8'h75, 0, 1, 0, 8'h75, 1, 1};
      vt[6]  = '{8'h75, 0, 1, 0, 8'h75, 0, 0};
      vt[7]  = '{8'h1C, 1, 0, 1, 8'h75, 0, 0};
      vt[8]  = '{8'h1C, 0, 1, 0, 8'h1C, 0, 0};
      vt[9]  = '{8'h00, 0, 1, 0, 8'h00, 0, 0};
      vt[10] = '{8'hE0, 0, 0, 0, 8'h00, 0, 0};
      vt[11] = '{8'hE0, 0, 0, 0, 8'h00, 0, 0};
      vt[12] = '{8'h1C, 0, 1, 0, 8'h1C, 0, 1};
      vt[13] = '{8'hF0, 0, 0, 0, 8'h1C, 0, 1};
      vt[14] = '{8'hF0, 0, 0, 0, 8'h1C, 0, 1};
      vt[15] = '{8'h14, 0, 1, 0, 8'h14, 1, 0};
      vt[16] = '{8'hE0, 0, 0, 0, 8'h14, 1, 0};
      vt[17] = '{8'h14, 1, 0, 1, 8'h14, 1, 0};
      vt[18] = '{8'h14, 0, 1, 0, 8'h14, 0, 0};

      clk_wait(3);
      check("rst code", ev.code, 0);
      check("rst brk", ev.is_break, 0);
      check("rst ext", ev.is_ext, 0);
      check("rst valid", ev.code_valid, 0);
      check("rst err", ev.frame_err, 0);
      check("rst busy", ev.busy, 0);
      reset = 1'b0;
      clk_wait(5);

      // Falling PS2_CLK with data high in IDLE is not a start bit.
      ps2_data = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ps2_clk = 1'b0;
         clk_wait(H);
         ps2_clk = 1'b1;
         clk_wait(H);
      end
      check("idle busy", ev.busy, 0);
      check("idle err", err_cnt, 0);

`ifdef PS2_FILTER_EN
      ps2_data = 1'b0;
      ps2_clk = 1'b0;
      clk_wait(3);
      ps2_clk = 1'b1;
      clk_wait(20);
      ps2_data = 1'b1;
      check("glitch busy", ev.busy, 0);
      check("glitch err", err_cnt, 0);
`endif

      for (int i = 0; i < 19; i++) begin
         got_q.delete();
         err_cnt = 0;
         send_bits(vt[i].b, vt[i].bad, 11);
         clk_wait(20);
         check($sformatf("v%0d nvalid", i), got_q.size(), vt[i].nv);
         check($sformatf("v%0d nerr", i), err_cnt, vt[i].ne);
         check($sformatf("v%0d code", i), ev.code, vt[i].code);
         check($sformatf("v%0d brk", i), ev.is_break, vt[i].brk);
         check($sformatf("v%0d ext", i), ev.is_ext, vt[i].ext);
         check($sformatf("v%0d busy", i), ev.busy, 0);
         if (i == 0)
            check("latency", last_valid_cyc - stop_cyc, LAT);
      end

      // Partial frame then silence: timeout abandons it.
      got_q.delete();
      err_cnt = 0;
      send_bits(8'h29, 0, 5);
      check("tmo busy hi", ev.busy, 1);
      clk_wait(TMO + 50);
      d = last_err_cyc - last_fall_cyc;
      check("tmo nerr", err_cnt, 1);
      check("tmo window", int'(d >= TMO + 1 && d <= TMO + 5), 1);
      check("tmo busy lo", ev.busy, 0);
      check("tmo nvalid", got_q.size(), 0);
      send_bits(8'h29, 0, 11);
      clk_wait(20);
      check("post tmo nvalid", got_q.size(), 1);
      check("post tmo code", ev.code, 8'h29);

      // Reset mid-frame with a pending E0 discards both.
      send_bits(8'hE0, 0, 11);
      clk_wait(20);
      send_bits(8'h5A, 0, 5);
      reset = 1'b1;
      clk_wait(2);
      check("mid rst code", ev.code, 0);
      check("mid rst busy", ev.busy, 0);
      check("mid rst valid", ev.code_valid, 0);
      check("mid rst err", ev.frame_err, 0);
      reset = 1'b0;
      clk_wait(5);
      got_q.delete();
      err_cnt = 0;
      send_bits(8'h5A, 0, 11);
      clk_wait(20);
      check("rst5A nvalid", got_q.size(), 1);
      check("rst5A code", ev.code, 8'h5A);
      check("rst5A brk", ev.is_break, 0);
      check("rst5A ext", ev.is_ext, 0);
      check("rst5A nerr", err_cnt, 0);

      got_q.delete();
      exp_q.delete();
      err_cnt = 0;
      exp_err = 0;
      m_ext = 0;
      m_brk = 0;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            0:       rb = 8'hE0;
            1:       rb = 8'hF0;
            default: rb = 8'($urandom_range(0, 255));
         endcase
         rbad = ($urandom_range(0, 9) == 0);
         model(rb, rbad);
         send_bits(rb, rbad, 11);
         clk_wait(4);
      end
      clk_wait(20);
      check("rand nvalid", got_q.size(), exp_q.size());
      check("rand nerr", err_cnt, exp_err);
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("rand ev%0d", i), got_q[i], exp_q[i]);

      check("valid/err overlap", overlap, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
